// File: rtl/imem_loader_if.sv
// Boot-loader / fetch bus between the byte-stream source, the cpu and imem_loader.
// master: loader source and cpu side; slave: the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic [7:0]        load_len;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output load_start, load_len, load_valid, load_data, imem_addr,
    input  load_ready, imem_data, cpu_hold, load_done, load_err
  );

  modport slave (
    input  load_start, load_len, load_valid, load_data, imem_addr,
    output load_ready, imem_data, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream boot loader in front of the cpu.
// A program arrives over load_valid/load_ready, is written from address 0,
// and only then is the cpu released (cpu_hold low) and shown real memory.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum
// byte; a bad sum parks the loader in ERR with the cpu held.
//
// state | meaning
// IDLE  | after reset, cpu held, waiting for load_start
// LOAD  | accepting program bytes, cpu held
// CHECK | (checksum build) accepting the checksum byte
// ERR   | (checksum build) checksum mismatch, cpu held, load_err high
// RUN   | cpu released, memory visible on imem_data
module imem_loader #(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] NOP_BYTE = 8'hC0
) (
  input logic           clk,
  input logic           areset,
  imem_loader_if.slave  bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ERR, RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [7:0]        count;
  logic              ready_q, hold_q, done_q;
  logic              accept, we, start_ok;
  logic [7:0]        mem [2**ADDR_W];

  assign accept   = bus.load_valid && ready_q;
  assign we       = (state == LOAD) && accept;
  // a start is honoured only from a state that leaves for LOAD because of it
  assign start_ok = (state_nxt == LOAD) && (state != LOAD);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum, chk_total;
  logic       err_q;
  assign chk_total = sum + bus.load_data;
`endif

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.load_start) state_nxt = LOAD;
      LOAD: begin
        if (accept && count == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = RUN;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (accept) state_nxt = (chk_total == 8'd0) ? RUN : ERR;
      ERR:   if (bus.load_start) state_nxt = LOAD;
`endif
      RUN:  if (bus.load_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // state register and registered handshake/status outputs, aligned with state
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ready_q <= (state_nxt == LOAD) || (state_nxt == CHECK);
`else
      ready_q <= (state_nxt == LOAD);
`endif
      hold_q  <= (state_nxt != RUN);
      done_q  <= (state_nxt == RUN) && (state != RUN);
    end
  end

  // write pointer and remaining-byte counter
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wptr  <= '0;
      count <= 8'd0;
    end else if (start_ok) begin
      wptr  <= '0;
      count <= bus.load_len;
    end else if (we) begin
      wptr  <= wptr + ADDR_W'(1);
      count <= count - 8'd1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // running checksum of program bytes and the error flag
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sum   <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (start_ok)  sum <= 8'd0;
      else if (we)   sum <= sum + bus.load_data;
      err_q <= (state_nxt == ERR);
    end
  end
  assign bus.load_err = err_q;
`else
  assign bus.load_err = 1'b0;
`endif

  // program array write; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= bus.load_data;
  end

  assign bus.load_ready = ready_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = done_q;
  assign bus.imem_data  = (state == RUN) ? mem[bus.imem_addr] : NOP_BYTE;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed boot scenarios plus randomized loads,
// checked against a byte-array model of the program memory.
module tb_imem_loader;
  logic clk = 1'b0;
  logic areset;
  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .NOP_BYTE(8'hC0)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_mem [256];
  bit         written   [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_len   = 8'd0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'd0;
    bus.imem_addr  = 8'd0;
  endtask

  task automatic start_load(input logic [7:0] len);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    step();
    bus.load_start = 1'b0;
    bus.load_len   = 8'($urandom);
    check("ready_in_load", bus.load_ready, 1);
    check("hold_in_load", bus.cpu_hold, 1);
    check("nop_in_load", bus.imem_data, 8'hC0);
  endtask

  // Offer bytes in order; valid follows pat for the first patlen cycles, then vpct%.
  // Byte k of the stream lands at address k.
  task automatic feed(input logic [7:0] data[$], input int vpct,
                      input logic [15:0] pat, input int patlen);
    int idx = 0;
    int cyc = 0;
    bit v;
    while (idx < data.size() && cyc < 5000) begin
      v = (cyc < patlen) ? pat[cyc] : ($urandom_range(99) < vpct);
      bus.load_valid = v;
      bus.load_data  = v ? data[idx] : 8'($urandom);
      bus.load_start = ($urandom_range(7) == 0);
      bus.imem_addr  = 8'($urandom);
      if (!v) check("nop_while_loading", bus.imem_data, 8'hC0);
      step();
      cyc++;
      if (v) begin
        model_mem[idx] = data[idx];
        written[idx]   = 1'b1;
        idx++;
      end
    end
    bus.load_valid = 1'b0;
    bus.load_start = 1'b0;
    if (cyc >= 5000) check("feed_timeout", 0, 1);
  endtask

  task automatic read_check(input logic [7:0] addr);
    logic [7:0] a;
    a = written[addr] ? addr : 8'd0;
    bus.imem_addr = a;
    #1;
    check("imem_read", bus.imem_data, model_mem[a]);
  endtask

  task automatic expect_run();
    check("done_pulse", bus.load_done, 1);
    check("hold_released", bus.cpu_hold, 0);
    check("ready_dropped", bus.load_ready, 0);
    check("err_clear", bus.load_err, 0);
    for (int i = 0; i < 4; i++) read_check(8'($urandom));
    step();
    check("done_one_cycle", bus.load_done, 0);
    check("hold_stays_low", bus.cpu_hold, 0);
  endtask

  task automatic complete(input logic [7:0] data[$], input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'd0;
    foreach (data[i]) s += data[i];
    bus.load_valid = 1'b1;
    bus.load_data  = good ? 8'(-s) : 8'(-s + 8'd1);
    check("ready_in_check", bus.load_ready, 1);
    step();
    bus.load_valid = 1'b0;
`endif
    if (good) begin
      expect_run();
    end else begin
      check("err_flag", bus.load_err, 1);
      check("err_hold", bus.cpu_hold, 1);
      check("err_no_done", bus.load_done, 0);
      check("err_nop", bus.imem_data, 8'hC0);
      step();
      check("err_sticky", bus.load_err, 1);
    end
  endtask

  task automatic full_load(input logic [7:0] data[$], input int vpct,
                           input logic [15:0] pat, input int patlen);
    start_load(8'(data.size() - 1));
    feed(data, vpct, pat, patlen);
    complete(data, 1'b1);
  endtask

  initial begin
    logic [7:0] d[$];
    foreach (written[i]) written[i] = 1'b0;
    idle_inputs();
    areset = 1'b1;
    repeat (2) step();
    areset = 1'b0;
    step();

    // reset state
    check("rst_hold", bus.cpu_hold, 1);
    check("rst_ready", bus.load_ready, 0);
    check("rst_done", bus.load_done, 0);
    check("rst_err", bus.load_err, 0);
    for (int a = 0; a < 4; a++) begin
      bus.imem_addr = 8'(a);
      #1;
      check("rst_nop", bus.imem_data, 8'hC0);
    end

    // four bytes, valid every cycle
    d = '{8'h41, 8'h14, 8'hC6, 8'h3F};
    full_load(d, 100, 16'h0, 0);
    bus.imem_addr = 8'd2; #1; check("t2_addr2", bus.imem_data, 8'hC6);
    bus.imem_addr = 8'd3; #1; check("t2_addr3", bus.imem_data, 8'h3F);

    // gapped valid 1,0,0,1,0,1
    d = '{8'hAA, 8'hBB, 8'hCC};
    full_load(d, 100, 16'b101001, 6);
    for (int a = 0; a < 3; a++) read_check(8'(a));

    // reset after two of eight bytes, then a one-byte reload
    start_load(8'd7);
    d = '{8'($urandom), 8'($urandom)};
    feed(d, 100, 16'h0, 0);
    check("partial_hold", bus.cpu_hold, 1);
    check("partial_no_done", bus.load_done, 0);
    areset = 1'b1;
    #1;
    check("async_rst_hold", bus.cpu_hold, 1);
    check("async_rst_ready", bus.load_ready, 0);
    step();
    areset = 1'b0;
    step();
    d = '{8'h55};
    full_load(d, 100, 16'h0, 0);
    read_check(8'd0);
    read_check(8'd1);
    check("reload_addr0", model_mem[0], 8'h55);

    // full 256-byte image with mem[i]=i
    d = {};
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    full_load(d, 80, 16'h0, 0);
    bus.imem_addr = 8'hFF; #1; check("wrap_addr_ff", bus.imem_data, 8'hFF);
    bus.imem_addr = 8'h00; #1; check("wrap_addr_00", bus.imem_data, 8'h00);
    // valid with ready low must not write
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hEE;
    step();
    step();
    bus.load_valid = 1'b0;
    bus.imem_addr = 8'h05; #1; check("no_write_in_run", bus.imem_data, 8'h05);
    // reload from RUN
    d = '{8'($urandom), 8'($urandom), 8'($urandom)};
    full_load(d, 60, 16'h0, 0);

    // randomized loads
    for (int n = 0; n < 6; n++) begin
      d = {};
      for (int i = 0; i <= int'($urandom_range(40)); i++) d.push_back(8'($urandom));
      full_load(d, int'($urandom_range(30, 100)), 16'h0, 0);
      for (int k = 0; k < 3; k++) read_check(8'($urandom_range(d.size() - 1)));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    d = '{8'h01, 8'h02, 8'h03};
    start_load(8'd2);
    feed(d, 100, 16'h0, 0);
    bus.load_valid = 1'b1; bus.load_data = 8'hFA;
    step();
    bus.load_valid = 1'b0;
    expect_run();
    start_load(8'd2);
    feed(d, 100, 16'h0, 0);
    complete(d, 1'b0);
    d = '{8'h10, 8'h20};
    full_load(d, 100, 16'h0, 0);
`else
    check("err_tied_low", bus.load_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
